mul_seq32: RTL and testbench
============================

Name: mul_seq32

Overview:
- Iterative radix-2 shift-and-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. Sits in the execute stage beside the ALU.
- Drives one Adder32b instance with the accumulator high half and the multiplicand each cycle, and consumes its S/COUT outputs.
- Uses a valid/ready handshake toward the decode/issue side and toward writeback.
- Multi-cycle: the pipeline stalls while IN_READY=0.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- CNT_W, 6, iteration counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous abort of the in-flight operation.
- IN_VALID  in  1  operands/OP valid.
- IN_READY  out  1  unit can accept; high only in IDLE.
- OP  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- A  in  32  rs1 operand.
- B  in  32  rs2 operand.
- OUT_VALID  out  1  RESULT valid; held until accepted.
- OUT_READY  in  1  consumer accepts RESULT.
- RESULT  out  32  low product word for MUL, high product word otherwise.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, counter=0, product register=0.
  - IN_READY=1, OUT_VALID=0, RESULT=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On IN_VALID&&IN_READY at cycle t, latch the operands.
  - Sign flags: sa = A[31]&(OP==MULH|OP==MULHSU); sb = B[31]&(OP==MULH).
  - Latch |A| if sa, else A, as the multiplicand M.
  - Load P[63:0] = {32'h0, |B| if sb, else B}.
  - Latch neg = sa^sb and OP. Go to CALC, counter=0.
- CALC (32 cycles, t+1..t+32):
  - Adder32b inputs: A=P[63:32], B = M if P[0] else 0, SUB=0.
  - Update P = {COUT, S, P[31:1]}.
  - counter++; after counter==31 go to FIX.
- FIX (1 cycle, t+33):
  - If neg, P = ~P + 1 (64-bit two's complement); else P unchanged. Go to DONE.
- DONE (from t+34):
  - OUT_VALID=1; RESULT = P[31:0] if OP==MUL, else P[63:32].
  - RESULT stays stable while OUT_VALID&&!OUT_READY.
  - On OUT_READY go to IDLE. IN_READY returns high the next cycle; no back-to-back accept in the DONE cycle.
- Fixed latency: 34 cycles from accept to OUT_VALID, unless the optional feature is compiled in.
- Boundary conditions:
  - Most-negative operand: |0x80000000| = 0x80000000 as unsigned 32-bit; the 64-bit result is still correct.
  - Operand 0: all iterations add 0; result 0; neg still applied, giving -0 = 0.
  - FLUSH in any state: next state IDLE, OUT_VALID=0, counter=0. FLUSH has priority over a same-cycle IN_VALID or OUT_READY; nothing is accepted that cycle.
  - IN_VALID outside IDLE is ignored; IN_READY=0.
  - Reset mid-operation: immediate return to IDLE; result discarded.
- OUT_VALID and IN_READY are registered state decodes; there are no combinational paths from inputs.

Optional Feature:
- Macro MUL_EARLY_EXIT_EN.
- Defined:
  - In CALC, if the remaining unprocessed multiplier bits are all zero, leave early.
  - Condition: P[31:0] >> (nothing consumed beyond the counter), i.e. the shifted-in remaining bits of the original multiplier == 0.
  - On early exit, shift P right by the remaining count (32-counter) in a single cycle, then go to FIX.
  - Latency varies from 3 to 34 cycles. Example: B=0 gives 3 cycles (accept, one CALC cycle, FIX).
- Undefined: fixed 34-cycle latency; no early-exit logic synthesised.

Decomposition:
- Shared package (alu_pkg):
  - OP encodings MUL_OP_MUL/MULH/MULHSU/MULHU.
  - State encoding typedef mul_state_t.
  - XLEN constant.
- Sub-module: reuse existing Adder32b for the per-iteration add. No new sub-module; the 64-bit negate stays inline in mul_seq32.

Test Plan:
- MUL A=7, B=0xFFFFFFFD (-3) -> RESULT 0xFFFFFFEB, OUT_VALID exactly 34 cycles after accept (no early exit).
- MULH A=0x80000000, B=0x80000000 -> RESULT 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU A=0xFFFFFFFF (-1), B=0xFFFFFFFF (unsigned) -> RESULT 0xFFFFFFFF; same operands with MUL -> 0x00000001.
- Hold OUT_READY=0 for 10 cycles in DONE -> OUT_VALID and RESULT stable, IN_READY=0. Raise OUT_READY -> IDLE the next cycle.
- Assert FLUSH at CALC counter=15 with IN_VALID=1 -> IDLE next cycle, no OUT_VALID, no accept. A new MUL 3×5 then yields 15.
- Pull RST_N low mid-CALC asynchronously -> outputs at reset values before the next CLK edge. With MUL_EARLY_EXIT_EN: MUL 0x1234×0 -> OUT_VALID after 3 cycles, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: RV32M multiply opcodes, the sequential
// multiplier state type and the datapath width.
package alu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } mul_state_t;

endpackage

// File: rtl/Adder32b.sv
// 32-bit adder/subtractor shared by the execute stage; SUB=1 computes A-B
// with COUT as the inverted borrow.
module Adder32b (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        SUB,
   output logic [31:0] S,
   output logic        COUT
);

   logic [31:0] b_eff;

   always_comb begin
      b_eff       = SUB ? ~B : B;
      {COUT, S}   = {1'b0, A} + {1'b0, b_eff} + {32'd0, SUB};
   end

endmodule

// File: rtl/mul_seq32.sv
// Radix-2 shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional build macro MUL_EARLY_EXIT_EN skips iterations once the remaining multiplier bits are zero.
module mul_seq32 #(
   parameter int unsigned XLEN  = alu_pkg::XLEN,
   parameter int unsigned CNT_W = 6
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            FLUSH,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [1:0]      OP,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [XLEN-1:0] RESULT
);

   alu_pkg::mul_state_t state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   p_q, p_d;
   logic [XLEN-1:0]     m_q, m_d;
   logic                neg_q, neg_d;
   logic [1:0]          op_q, op_d;

   logic [XLEN-1:0]     add_b;
   logic [XLEN-1:0]     add_s;
   logic                add_cout;
   logic                sa, sb;

`ifdef MUL_EARLY_EXIT_EN
   logic [XLEN-1:0]     rem_mask;
   logic [CNT_W:0]      shamt;
`endif

   assign add_b = p_q[0] ? m_q : '0;

   Adder32b u_add (
      .A    (p_q[2*XLEN-1:XLEN]),
      .B    (add_b),
      .SUB  (1'b0),
      .S    (add_s),
      .COUT (add_cout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      m_d     = m_q;
      neg_d   = neg_q;
      op_d    = op_q;
      sa      = A[XLEN-1] & ((OP == alu_pkg::MUL_OP_MULH) | (OP == alu_pkg::MUL_OP_MULHSU));
      sb      = B[XLEN-1] & (OP == alu_pkg::MUL_OP_MULH);
`ifdef MUL_EARLY_EXIT_EN
      // Unconsumed multiplier bits sit in P[31-cnt:0]; once zero, the rest is a pure shift.
      rem_mask = {XLEN{1'b1}} >> cnt_q;
      shamt    = (CNT_W+1)'(XLEN) - {1'b0, cnt_q};
`endif
      if (FLUSH) begin
         state_d = alu_pkg::ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            alu_pkg::ST_IDLE: begin
               if (IN_VALID) begin
                  m_d     = sa ? (~A + 1'b1) : A;
                  p_d     = {{XLEN{1'b0}}, (sb ? (~B + 1'b1) : B)};
                  neg_d   = sa ^ sb;
                  op_d    = OP;
                  cnt_d   = '0;
                  state_d = alu_pkg::ST_CALC;
               end
            end
            alu_pkg::ST_CALC: begin
`ifdef MUL_EARLY_EXIT_EN
               if ((p_q[XLEN-1:0] & rem_mask) == '0) begin
                  p_d     = p_q >> shamt;
                  cnt_d   = '0;
                  state_d = alu_pkg::ST_FIX;
               end else
`endif
               begin
                  p_d   = {add_cout, add_s, p_q[XLEN-1:1]};
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(XLEN-1)) begin
                     state_d = alu_pkg::ST_FIX;
                  end
               end
            end
            alu_pkg::ST_FIX: begin
               if (neg_q) begin
                  p_d = ~p_q + 1'b1;
               end
               state_d = alu_pkg::ST_DONE;
            end
            alu_pkg::ST_DONE: begin
               if (OUT_READY) begin
                  state_d = alu_pkg::ST_IDLE;
               end
            end
            default: state_d = alu_pkg::ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= alu_pkg::ST_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         m_q     <= '0;
         neg_q   <= 1'b0;
         op_q    <= alu_pkg::MUL_OP_MUL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         m_q     <= m_d;
         neg_q   <= neg_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      IN_READY  = (state_q == alu_pkg::ST_IDLE);
      OUT_VALID = (state_q == alu_pkg::ST_DONE);
      RESULT    = '0;
      if (state_q == alu_pkg::ST_DONE) begin
         RESULT = (op_q == alu_pkg::MUL_OP_MUL) ? p_q[XLEN-1:0] : p_q[2*XLEN-1:XLEN];
      end
   end

endmodule

// File: tb/tb_mul_seq32.sv
// Directed bench for mul_seq32: hand-computed products, latency, handshake,
// flush and asynchronous reset behaviour.
module tb_mul_seq32;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int vectors;
   int miscompares;
   int lat;

`ifdef MUL_EARLY_EXIT_EN
   localparam int ZERO_B_LAT = 3;
`else
   localparam int ZERO_B_LAT = 34;
`endif

   mul_seq32 #(.XLEN(32), .CNT_W(6)) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .FLUSH     (flush),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .OP        (op),
      .A         (a),
      .B         (b),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .RESULT    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation at a negedge; returns edges from accept edge to OUT_VALID (0 on timeout).
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int l);
      @(negedge clk);
      chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      l = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            l = i;
            break;
         end
      end
      if (l == 0) chk("out_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("retire_out_valid_low", {63'd0, out_valid}, 64'd0);
      chk("retire_in_ready_high", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp);
      issue(o, x, y, lat);
      chk(tag, {32'd0, result}, {32'd0, exp});
      retire();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      op          = 2'b00;
      a           = '0;
      b           = '0;
      out_ready   = 1'b0;

      #12;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_result", {32'd0, result}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // MUL 7 * -3, full-length latency
      issue(2'b00, 32'd7, 32'hFFFF_FFFD, lat);
      chk("mul_7_m3", {32'd0, result}, 64'h0000_0000_FFFF_FFEB);
      chk("mul_latency", lat, 64'd34);
      // hold in DONE without acceptance; new IN_VALID must be ignored
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_result", {32'd0, result}, 64'h0000_0000_FFFF_FFEB);
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      retire();

      run("mulh_min_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run("mulhu_max_max",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run("mulhsu_m1_max",  2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("mul_m1_max",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      run("mulh_m1_5",      2'b01, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF);
      run("mulh_min_1",     2'b01, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF);
      run("mulhsu_min_2p31",2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);
      run("mulh_0_min",     2'b01, 32'd0,         32'h8000_0000, 32'h0000_0000);
      run("mulhu_pos",      2'b11, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003);

      // zero multiplier: 3-cycle early exit when compiled in, else full latency
      issue(2'b00, 32'h0000_1234, 32'd0, lat);
      chk("mul_x_0", {32'd0, result}, 64'd0);
      chk("zero_b_latency", lat, ZERO_B_LAT);
      retire();

      // flush at counter 15 with a competing IN_VALID
      @(negedge clk);
      op       = 2'b00;
      a        = 32'd9;
      b        = 32'hFFFF_FFFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 15; i++) @(posedge clk);
      @(negedge clk);
      chk("calc_in_ready_low", {63'd0, in_ready}, 64'd0);
      flush    = 1'b1;
      in_valid = 1'b1;
      a        = 32'd2;
      b        = 32'd2;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_idle", {63'd0, in_ready}, 64'd1);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("flush_no_accept", {63'd0, in_ready}, 64'd1);
      chk("flush_no_result", {63'd0, out_valid}, 64'd0);
      run("mul_3_5_after_flush", 2'b00, 32'd3, 32'd5, 32'd15);

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      op       = 2'b11;
      a        = 32'hFFFF_FFFF;
      b        = 32'hFFFF_FFFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 10; i++) @(posedge clk);
      #2;
      chk("pre_reset_busy", {63'd0, in_ready}, 64'd0);
      rst_n = 1'b0;
      #1;
      chk("async_reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("async_reset_result", {32'd0, result}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run("mul_after_reset", 2'b00, 32'd1000, 32'd1000, 32'd1000000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
